active_list: RTL and testbench
==============================

# active_list

In-order retirement buffer (active list / ROB) that sits behind the register map table in the rename stage. It accepts one renamed instruction per cycle with its previous physical/logical destination mapping. It accepts out-of-order completion notices by tag, and retires the oldest entry once it is complete. On retirement it returns the superseded physical register to the map table's free list through the commit interface.

## Interface
Parameters:
- DEPTH, 32, number of entries; power of two, ≥4
- TAG_W, $clog2(DEPTH), entry tag width
- PREG_W, 6, physical register index width (64 physical regs)
- LREG_W, 5, logical register index width (32 MIPS regs)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset rst_n, synchronous, active-low
- disp_valid  in  1  rename stage presents an instruction
- disp_ready  out  1  list can accept; = (count < DEPTH)
- disp_uses_rw  in  1  instruction writes a destination
- disp_prev_preg  in  PREG_W  physical reg previously mapped to the destination
- disp_lreg  in  LREG_W  logical destination register
- disp_tag  out  TAG_W  tag assigned to the dispatching instruction; = tail pointer
- cmpl_valid  in  1  execution reports completion
- cmpl_tag  in  TAG_W  tag of the completed instruction
- commit_valid  out  1  head entry retires this cycle
- commit_free_en  out  1  drives Reg_WR_EN of the commit interface; = commit_valid & head.uses_rw
- commit_free_preg  out  PREG_W  drives reg_addr; head.prev_preg
- commit_lreg  out  LREG_W  head.lreg, for debug/architectural tracking
- count  out  TAG_W+1  number of occupied entries

## Operation
- Storage: per entry valid, done, uses_rw, prev_preg, lreg. head_ptr and tail_ptr are TAG_W-bit and wrap modulo DEPTH. count is tracked explicitly, so full (count==DEPTH) and empty (count==0) are unambiguous when head==tail.
- Dispatch: a dispatch occurs on a rising edge when disp_valid & disp_ready. The entry at tail_ptr is written with valid=1, done=0 and the payload. tail_ptr increments, wrapping DEPTH-1→0.
- Completion: on a rising edge with cmpl_valid, the entry at cmpl_tag gets done=1 only if that entry's valid is 1.
  - Completion to an invalid entry is ignored.
  - A repeated completion is idempotent.
- Commit (combinational from head): commit_valid = (count!=0) & head.valid & head.done. When commit_valid is 1 at a rising edge, the head entry is cleared (valid=0, done=0) and head_ptr increments with wrap. At most one commit per cycle.
- Retirement order is strictly in dispatch order regardless of completion order.
- Entries with uses_rw=0 still retire and pulse commit_valid, but commit_free_en=0.
- count update: dispatch only → +1; commit only → −1; both → unchanged.
- Full: disp_ready=0 whenever count==DEPTH, even if a commit happens the same cycle. There is no same-cycle slot reuse.
- Reset (rst_n=0 at an edge) clears, regardless of in-flight dispatch, completion or commit:
  - head_ptr=tail_ptr=0, count=0
  - all valid and done bits = 0
  - payload fields need not be cleared

## Timing
- Outputs after reset: disp_ready=1, disp_tag=0, count=0, commit_valid=0, commit_free_en=0. commit_free_preg and commit_lreg are don't-care while commit_valid=0.
- Dispatch at edge N makes the entry visible from cycle N+1. A completion for that tag is legal from cycle N+1 onward.
- Completion registered at edge M for the head entry gives commit_valid=1 in cycle M+1. The free-list release happens at the map table on edge M+2.
- A completion and a commit of the same tag in the same cycle cannot occur, because done must already be 1 for the commit.
- Same-cycle dispatch, completion (different tag) and commit are all honoured independently.
- disp_ready and disp_tag depend only on registered state, with no combinational path from disp_valid.

## Test plan
- Reset/idle: hold rst_n=0 for 2 cycles, then release → disp_ready=1, count=0, commit_valid=0, disp_tag=0. Assert rst_n=0 with 5 entries live → count=0 the next cycle and no commit pulses.
- In-order retire, out-of-order completion: dispatch tags 0,1,2 with prev_preg 40,41,42; complete 2, then 0, then 1 → commit pulses in order: preg 40 in the cycle after tag 0 completes, then 41 and 42 on consecutive cycles.
- Full: dispatch 32 entries with no completion → count=32, disp_ready=0. A held disp_valid is not accepted and disp_tag stays 0. Complete tag 0 → one commit, then disp_ready=1 and the next dispatch gets tag 0.
- Wrap-around: run 100 dispatches with immediate completions → tags cycle 0..31 repeatedly. The commit_free_preg sequence exactly equals the dispatched prev_preg sequence, and count never exceeds DEPTH.
- Simultaneous dispatch and commit at count=5 → count stays 5, tail and head both advance by 1, and both events take effect.
- Non-writing entry and stray completion:
  - Dispatch with uses_rw=0 and complete it → commit_valid=1 with commit_free_en=0.
  - Completion to an unallocated tag → no state change and no commit.

Source files
------------

// File: rtl/active_list.sv
// active_list
// In-order retirement buffer (active list / ROB) behind the register map
// table. Accepts one renamed instruction per cycle, marks entries done on
// out-of-order completion notices, and retires the oldest entry once it is
// done, handing its superseded physical register back to the free list.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   disp_valid/ready    dispatch handshake; transfer when both high at an edge
//   disp_uses_rw        instruction writes a destination register
//   disp_prev_preg      physical reg previously mapped to the destination
//   disp_lreg           logical destination register
//   disp_tag            tag given to the dispatching instruction (tail pointer)
//   cmpl_valid/tag      completion notice for an entry
//   commit_valid        head entry retires this cycle
//   commit_free_en      free-list write enable (commit_valid & head.uses_rw)
//   commit_free_preg    physical register being released (head.prev_preg)
//   commit_lreg         logical register of the retiring entry
//   count               number of occupied entries
//
// Handshake: a dispatch happens on a rising edge where disp_valid and
// disp_ready are both 1. disp_ready depends only on registered state, so the
// producer may hold disp_valid and wait; there is no path from disp_valid.
module active_list #(
   parameter int DEPTH  = 32,
   parameter int TAG_W  = $clog2(DEPTH),
   parameter int PREG_W = 6,
   parameter int LREG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disp_valid,
   output logic              disp_ready,
   input  logic              disp_uses_rw,
   input  logic [PREG_W-1:0] disp_prev_preg,
   input  logic [LREG_W-1:0] disp_lreg,
   output logic [TAG_W-1:0]  disp_tag,
   input  logic              cmpl_valid,
   input  logic [TAG_W-1:0]  cmpl_tag,
   output logic              commit_valid,
   output logic              commit_free_en,
   output logic [PREG_W-1:0] commit_free_preg,
   output logic [LREG_W-1:0] commit_lreg,
   output logic [TAG_W:0]    count
);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [DEPTH-1:0]  uses_rw_q, uses_rw_d;
   logic [PREG_W-1:0] prev_preg_q [DEPTH];
   logic [PREG_W-1:0] prev_preg_d [DEPTH];
   logic [LREG_W-1:0] lreg_q [DEPTH];
   logic [LREG_W-1:0] lreg_d [DEPTH];
   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;

   logic do_disp;
   logic do_commit;

   // Full blocks dispatch even if the head retires this same cycle; a freed
   // slot is only reusable from the next cycle.
   assign disp_ready = (count_q != (TAG_W+1)'(DEPTH));
   assign disp_tag   = tail_q;
   assign count      = count_q;

   assign do_disp   = disp_valid & disp_ready;
   assign do_commit = (count_q != '0) & valid_q[head_q] & done_q[head_q];

   assign commit_valid     = do_commit;
   assign commit_free_en   = do_commit & uses_rw_q[head_q];
   assign commit_free_preg = prev_preg_q[head_q];
   assign commit_lreg      = lreg_q[head_q];

   always_comb begin
      valid_d     = valid_q;
      done_d      = done_q;
      uses_rw_d   = uses_rw_q;
      prev_preg_d = prev_preg_q;
      lreg_d      = lreg_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;

      // Completion is applied before the commit clear so that a repeated
      // completion aimed at the retiring head cannot resurrect its done bit.
      if (cmpl_valid && valid_q[cmpl_tag]) begin
         done_d[cmpl_tag] = 1'b1;
      end

      if (do_commit) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
         head_d          = head_q + TAG_W'(1);
      end

      // The tail slot is never valid when not full, so it cannot collide
      // with the head being cleared or with an accepted completion.
      if (do_disp) begin
         valid_d[tail_q]     = 1'b1;
         done_d[tail_q]      = 1'b0;
         uses_rw_d[tail_q]   = disp_uses_rw;
         prev_preg_d[tail_q] = disp_prev_preg;
         lreg_d[tail_q]      = disp_lreg;
         tail_d              = tail_q + TAG_W'(1);
      end

      case ({do_disp, do_commit})
         2'b10:   count_d = count_q + (TAG_W+1)'(1);
         2'b01:   count_d = count_q - (TAG_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload is only read behind a valid bit, so it is left out of reset.
   always_ff @(posedge clk) begin
      uses_rw_q   <= uses_rw_d;
      prev_preg_q <= prev_preg_d;
      lreg_q      <= lreg_d;
   end

endmodule

// File: tb/tb_active_list.sv
module tb_active_list;

   localparam int DEPTH  = 32;
   localparam int TAG_W  = 5;
   localparam int PREG_W = 6;
   localparam int LREG_W = 5;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              disp_valid = 1'b0;
   logic              disp_ready;
   logic              disp_uses_rw = 1'b0;
   logic [PREG_W-1:0] disp_prev_preg = '0;
   logic [LREG_W-1:0] disp_lreg = '0;
   logic [TAG_W-1:0]  disp_tag;
   logic              cmpl_valid = 1'b0;
   logic [TAG_W-1:0]  cmpl_tag = '0;
   logic              commit_valid;
   logic              commit_free_en;
   logic [PREG_W-1:0] commit_free_preg;
   logic [LREG_W-1:0] commit_lreg;
   logic [TAG_W:0]    count;

   active_list #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .LREG_W(LREG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_uses_rw(disp_uses_rw), .disp_prev_preg(disp_prev_preg),
      .disp_lreg(disp_lreg), .disp_tag(disp_tag),
      .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
      .commit_valid(commit_valid), .commit_free_en(commit_free_en),
      .commit_free_preg(commit_free_preg), .commit_lreg(commit_lreg),
      .count(count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: in-flight instructions in program order, oldest first.
   int m_head = 0;
   int m_prev[$];
   int m_lreg[$];
   bit m_rw[$];
   bit m_done[$];

   // observed and expected retirement streams (prev_preg values)
   logic [PREG_W-1:0] obs_q[$];
   logic [PREG_W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_head = 0;
      m_prev.delete();
      m_lreg.delete();
      m_rw.delete();
      m_done.delete();
   endtask

   // One clock cycle: drive inputs, check outputs against the model,
   // advance the model, then cross the rising edge.
   task automatic step(input bit dv, input bit rw, input int prev, input int lr,
                       input bit cv, input int ct);
      int  size;
      bit  exp_cv;
      bit  exp_disp;
      int  k;
      logic [31:0] pv;
      logic [31:0] lv;
      logic [31:0] tv;
      pv = prev;
      lv = lr;
      tv = ct;
      disp_valid     = dv;
      disp_uses_rw   = rw;
      disp_prev_preg = pv[PREG_W-1:0];
      disp_lreg      = lv[LREG_W-1:0];
      cmpl_valid     = cv;
      cmpl_tag       = tv[TAG_W-1:0];
      #1;
      size   = m_prev.size();
      exp_cv = (size > 0) && m_done[0];
      check_eq("disp_ready", disp_ready, size < DEPTH);
      check_eq("disp_tag", disp_tag, (m_head + size) % DEPTH);
      check_eq("count", count, size);
      check_eq("count_le_depth", count <= DEPTH, 1);
      check_eq("commit_valid", commit_valid, exp_cv);
      if (exp_cv) begin
         check_eq("commit_free_en", commit_free_en, m_rw[0]);
         check_eq("commit_free_preg", commit_free_preg, m_prev[0]);
         check_eq("commit_lreg", commit_lreg, m_lreg[0]);
      end else begin
         check_eq("commit_free_en_idle", commit_free_en, 0);
      end
      if (commit_valid === 1'b1) obs_q.push_back(commit_free_preg);

      if (!rst_n) begin
         model_clear();
      end else begin
         exp_disp = dv && (size < DEPTH);
         if (cv) begin
            k = (ct - m_head + DEPTH) % DEPTH;
            if (k < size) m_done[k] = 1'b1;
         end
         if (exp_cv) begin
            void'(m_prev.pop_front());
            void'(m_lreg.pop_front());
            void'(m_rw.pop_front());
            void'(m_done.pop_front());
            m_head = (m_head + 1) % DEPTH;
         end
         if (exp_disp) begin
            m_prev.push_back(prev % (1 << PREG_W));
            m_lreg.push_back(lr % (1 << LREG_W));
            m_rw.push_back(rw);
            m_done.push_back(1'b0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   task automatic dispatch(input bit rw, input int prev);
      step(1, rw, prev, $urandom_range(0, 31), 0, 0);
   endtask

   task automatic complete(input int ct);
      step(0, 0, 0, 0, 1, ct);
   endtask

   initial begin
      // reset held for two edges, then idle checks
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      #1;
      check_eq("rst_disp_ready", disp_ready, 1);
      check_eq("rst_count", count, 0);
      check_eq("rst_commit_valid", commit_valid, 0);
      check_eq("rst_disp_tag", disp_tag, 0);
      idle(2);

      // in-order retirement with out-of-order completion
      obs_q.delete();
      dispatch(1, 40);
      dispatch(1, 41);
      dispatch(1, 42);
      complete(2);
      complete(0);
      check_eq("ooo_first_commit", commit_valid, 1);
      check_eq("ooo_first_preg", commit_free_preg, 40);
      complete(1);
      idle(4);
      exp_q = '{6'd40, 6'd41, 6'd42};
      check_eq("ooo_n_commits", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check_eq("ooo_order", obs_q[i], exp_q[i]);

      // full list
      do_reset();
      for (int i = 0; i < DEPTH; i++) dispatch(1, $urandom_range(0, 63));
      check_eq("full_count", count, DEPTH);
      check_eq("full_ready", disp_ready, 0);
      for (int i = 0; i < 3; i++) dispatch(1, 7);
      check_eq("full_tag_held", disp_tag, 0);
      step(1, 1, 9, 3, 1, 0);            // complete tag 0 while still full
      check_eq("full_commit", commit_valid, 1);
      check_eq("full_ready_at_commit", disp_ready, 0);
      step(1, 1, 9, 3, 0, 0);            // commit cycle, dispatch refused
      check_eq("full_ready_after", disp_ready, 1);
      check_eq("full_next_tag", disp_tag, 0);
      dispatch(1, 11);
      check_eq("full_refill_count", count, DEPTH);

      // reset with live entries
      do_reset();
      for (int i = 0; i < 5; i++) dispatch(1, i + 20);
      complete(0);
      rst_n = 1'b0;
      step(1, 1, 5, 5, 1, 1);
      rst_n = 1'b1;
      check_eq("live_rst_count", count, 0);
      check_eq("live_rst_commit", commit_valid, 0);
      idle(2);

      // wrap-around with immediate completions
      do_reset();
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 100; i++) begin
         int p;
         p = $urandom_range(0, 63);
         exp_q.push_back(p[PREG_W-1:0]);
         step(1, 1, p, $urandom_range(0, 31), i > 0, (i + DEPTH - 1) % DEPTH);
      end
      complete(99 % DEPTH);
      idle(3);
      check_eq("wrap_n_commits", obs_q.size(), 100);
      for (int i = 0; i < 100 && i < obs_q.size(); i++)
         check_eq("wrap_preg_seq", obs_q[i], exp_q[i]);

      // simultaneous dispatch and commit at count 5
      do_reset();
      for (int i = 0; i < 5; i++) dispatch(1, i + 30);
      complete(0);
      check_eq("sim_count_before", count, 5);
      check_eq("sim_tag_before", disp_tag, 5);
      dispatch(1, 50);
      check_eq("sim_count_after", count, 5);
      check_eq("sim_tag_after", disp_tag, 6);
      complete(1);
      check_eq("sim_next_head_preg", commit_free_preg, 31);

      // non-writing entry, then stray completion
      do_reset();
      dispatch(0, 17);
      complete(0);
      check_eq("norw_commit_valid", commit_valid, 1);
      check_eq("norw_free_en", commit_free_en, 0);
      idle(1);
      complete(10);
      check_eq("stray_count", count, 0);
      check_eq("stray_commit", commit_valid, 0);
      dispatch(1, 3);
      complete(20);
      idle(2);
      check_eq("stray_live_commit", commit_valid, 0);
      check_eq("stray_live_count", count, 1);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit dv;
         bit cv;
         int ct;
         int size;
         size = m_prev.size();
         dv = ($urandom_range(0, 3) != 0);
         cv = ($urandom_range(0, 1) != 0);
         if (size > 0 && $urandom_range(0, 9) < 8)
            ct = (m_head + $urandom_range(0, size - 1)) % DEPTH;
         else
            ct = $urandom_range(0, DEPTH - 1);
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         step(dv, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 31), cv, ct);
         rst_n = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
